bus_cycle_controller: RTL

Sequences every external bus transaction of the CPU: memory/IO reads and writes requested by the microcode sequencer, wait-state stretching from `pin_wait`, DMA bus hand-over (`dma_req`/`dma_ack`) and the halt state. Sits between `cpu_top`'s MAR/MDR datapath and the chip pins. It owns `address_bus`, `data_bus_out`, `rd`, `wr`, `mem_io`, `halt` and `dma_ack`, all of them registered. While a cycle is in flight, the microcode stalls on `cpu_done`.

---
 rtl/bus_cycle_controller.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/bus_cycle_controller.sv
// External bus cycle sequencer: read/write cycles with wait-state stretching,
// DMA bus hand-over and the CPU halt state. Every pin-facing output is a flop.
module bus_cycle_controller #(
  parameter int ADDR_W     = 22,
  parameter int STROBE_CYC = 1,
  parameter int WAIT_MAX   = 255
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_mem_io,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  input  logic              cpu_halt_req,
  input  logic              irq_wake,
  input  logic              dma_req,
  input  logic              pin_wait,
  input  logic [7:0]        data_bus_in,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_done,
  output logic              timeout_err,
  output logic [ADDR_W-1:0] address_bus,
  output logic [7:0]        data_bus_out,
  output logic              data_bus_oe,
  output logic              rd,
  output logic              wr,
  output logic              mem_io,
  output logic              halt,
  output logic              dma_ack,
  output logic              bus_tristate
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_DMA, S_HALT
  } state_t;

  localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYC - 1);
  localparam logic [7:0] WAIT_LAST   = 8'(WAIT_MAX - 1);

  state_t              state_q, state_d;
  logic [1:0]          dma_sync_q, wait_sync_q;
  logic [7:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic                to_q, to_d;
  logic                ret_halt_q, ret_halt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                mio_q, mio_d;
  logic [7:0]          rdata_q, rdata_d;
  logic                rd_q, wr_q, oe_q, done_q, terr_q, halt_q, ack_q, tri_q;
  logic                dma_s, wait_s, busy_d;

  assign dma_s  = dma_sync_q[1];
  assign wait_s = wait_sync_q[1];

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    to_d       = to_q;
    ret_halt_d = ret_halt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mio_d      = mio_q;
    rdata_d    = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (dma_s) begin
          state_d    = S_DMA;
          ret_halt_d = 1'b0;
        end else if (cpu_halt_req) begin
          state_d = S_HALT;
        end else if (cpu_req) begin
          addr_d  = cpu_addr;
          mio_d   = cpu_mem_io;
          we_d    = cpu_we;
          wdata_d = cpu_wdata;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = '0;
        to_d    = 1'b0;
        state_d = S_STROBE;
      end
      S_STROBE: begin
        cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        // A normal exit wins over a timeout landing on the same count.
        if (cnt_q >= STROBE_LAST && !wait_s) begin
          state_d = S_HOLD;
          if (!we_q) rdata_d = data_bus_in;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = S_HOLD;
          to_d    = 1'b1;
          if (!we_q) rdata_d = 8'hFF;
        end
      end
      S_HOLD: state_d = S_IDLE;
      S_DMA: begin
        if (!dma_s) state_d = ret_halt_q ? S_HALT : S_IDLE;
      end
      S_HALT: begin
        if (dma_s) begin
          state_d    = S_DMA;
          ret_halt_d = 1'b1;
        end else if (irq_wake) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_d = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);

  // Output flops decode the next state so pins line up with the state they describe.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      dma_sync_q  <= '0;
      wait_sync_q <= '0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      to_q        <= 1'b0;
      ret_halt_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mio_q       <= 1'b0;
      rdata_q     <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      oe_q        <= 1'b0;
      done_q      <= 1'b0;
      terr_q      <= 1'b0;
      halt_q      <= 1'b0;
      ack_q       <= 1'b0;
      tri_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let the synchronizer stages shift without ordering hazards.
      dma_sync_q  <= {dma_sync_q[0], dma_req};
      wait_sync_q <= {wait_sync_q[0], pin_wait};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      to_q        <= to_d;
      ret_halt_q  <= ret_halt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mio_q       <= mio_d;
      rdata_q     <= rdata_d;
      rd_q        <= (state_d == S_STROBE) && !we_d;
      wr_q        <= (state_d == S_STROBE) && we_d;
      oe_q        <= busy_d && we_d;
      done_q      <= (state_d == S_HOLD);
      terr_q      <= (state_d == S_HOLD) && to_d;
      halt_q      <= (state_d == S_HALT);
      ack_q       <= (state_d == S_DMA);
      tri_q       <= (state_d == S_DMA) || (state_d == S_HALT);
    end
  end

  assign cpu_rdata    = rdata_q;
  assign cpu_done     = done_q;
  assign timeout_err  = terr_q;
  assign address_bus  = addr_q;
  assign data_bus_out = wdata_q;
  assign data_bus_oe  = oe_q;
  assign rd           = rd_q;
  assign wr           = wr_q;
  assign mem_io       = mio_q;
  assign halt         = halt_q;
  assign dma_ack      = ack_q;
  assign bus_tristate = tri_q;

endmodule
